// File: rtl/rx_cmd_frame_parser_if.sv
// Byte-stream input and decoded-command output bundle for rx_cmd_frame_parser.
// The slave modport is the parser's view; master is the producer/consumer side.
interface rx_cmd_frame_parser_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [WIDTH-1:0]      rx_data;
    logic                  rx_valid;
    logic                  cmd_ready;
    logic                  cmd_valid;
    logic [1:0]            cmd_type;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0]      cmd_wdata;
    logic [WIDTH-1:0]      cmd_op_a;
    logic [WIDTH-1:0]      cmd_op_b;
    logic [3:0]            cmd_func;
    logic                  opcode_err;
    logic                  timeout_err;
    logic                  overrun_err;

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b,
               cmd_func, opcode_err, timeout_err, overrun_err
    );

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b,
               cmd_func, opcode_err, timeout_err, overrun_err
    );
endinterface

// File: rtl/rx_cmd_frame_parser.sv
// Assembles synchronised UART bytes into host command frames and hands each
// decoded command to the controller over a valid/ready handshake.
module rx_cmd_frame_parser #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1024,
    parameter int TO_WIDTH   = 16
) (
    input  logic clk,
    input  logic rst,
    rx_cmd_frame_parser_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, HOLD
    } state_t;

    localparam logic [WIDTH-1:0]    OP_RF_WR   = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0]    OP_RF_RD   = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0]    OP_ALU_OP  = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0]    OP_ALU_NOP = WIDTH'(8'hDD);
    localparam logic [TO_WIDTH-1:0] TO_LAST    = (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);

    state_t              state_r;
    logic [TO_WIDTH-1:0] to_cnt_r;
    logic                op_known_s;
    logic [1:0]          op_type_s;
    state_t              op_next_s;
    logic                accept_op_s;
    logic                to_expire_s;

    // Opcode byte lookup: command type and first collection state.
    always_comb begin
        op_known_s = 1'b1;
        op_type_s  = 2'd0;
        op_next_s  = IDLE;
        case (bus.rx_data)
            OP_RF_WR:   begin op_type_s = 2'd0; op_next_s = GET_ADDR; end
            OP_RF_RD:   begin op_type_s = 2'd1; op_next_s = GET_ADDR; end
            OP_ALU_OP:  begin op_type_s = 2'd2; op_next_s = GET_OPA;  end
            OP_ALU_NOP: begin op_type_s = 2'd3; op_next_s = GET_FUNC; end
            default:    op_known_s = 1'b0;
        endcase
    end

    // An opcode is taken in IDLE, or in HOLD when the pending command leaves at the same edge.
    assign accept_op_s = bus.rx_valid &&
                         ((state_r == IDLE) || ((state_r == HOLD) && bus.cmd_ready));
    assign to_expire_s = (TIMEOUT != 0) && (to_cnt_r == TO_LAST) && !bus.rx_valid;

    // Frame FSM, inter-byte timeout counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= IDLE;
            to_cnt_r        <= '0;
            bus.cmd_valid   <= 1'b0;
            bus.cmd_type    <= 2'd0;
            bus.cmd_addr    <= '0;
            bus.cmd_wdata   <= '0;
            bus.cmd_op_a    <= '0;
            bus.cmd_op_b    <= '0;
            bus.cmd_func    <= 4'd0;
            bus.opcode_err  <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            bus.opcode_err  <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.overrun_err <= 1'b0;
            to_cnt_r        <= '0;
            case (state_r)
                IDLE: begin
                end
                HOLD: begin
                    if (bus.cmd_ready) begin
                        bus.cmd_valid <= 1'b0;
                        state_r       <= IDLE;
                    end else if (bus.rx_valid) begin
                        bus.overrun_err <= 1'b1;
                    end else begin
                    end
                end
                GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC: begin
                    if (bus.rx_valid) begin
                        case (state_r)
                            GET_ADDR: begin
                                bus.cmd_addr <= bus.rx_data[ADDR_WIDTH-1:0];
                                if (bus.cmd_type == 2'd1) begin
                                    bus.cmd_valid <= 1'b1;
                                    state_r       <= HOLD;
                                end else begin
                                    state_r <= GET_DATA;
                                end
                            end
                            GET_DATA: begin
                                bus.cmd_wdata <= bus.rx_data;
                                bus.cmd_valid <= 1'b1;
                                state_r       <= HOLD;
                            end
                            GET_OPA: begin
                                bus.cmd_op_a <= bus.rx_data;
                                state_r      <= GET_OPB;
                            end
                            GET_OPB: begin
                                bus.cmd_op_b <= bus.rx_data;
                                state_r      <= GET_FUNC;
                            end
                            default: begin
                                bus.cmd_func  <= bus.rx_data[3:0];
                                bus.cmd_valid <= 1'b1;
                                state_r       <= HOLD;
                            end
                        endcase
                    end else if (to_expire_s) begin
                        bus.timeout_err <= 1'b1;
                        state_r         <= IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_WIDTH'(1);
                    end
                end
                default: state_r <= IDLE;
            endcase

            // Later assignments here override the HOLD->IDLE transition above.
            if (accept_op_s) begin
                if (op_known_s) begin
                    state_r       <= op_next_s;
                    bus.cmd_type  <= op_type_s;
                    bus.cmd_addr  <= '0;
                    bus.cmd_wdata <= '0;
                    bus.cmd_op_a  <= '0;
                    bus.cmd_op_b  <= '0;
                    bus.cmd_func  <= 4'd0;
                end else begin
                    bus.opcode_err <= 1'b1;
                end
            end else begin
            end
        end
    end
endmodule

// File: tb/tb_rx_cmd_frame_parser.sv
// Directed self-checking bench for rx_cmd_frame_parser (timeout shortened to 8).
module tb_rx_cmd_frame_parser;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    rx_cmd_frame_parser_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus ();

    rx_cmd_frame_parser #(
        .WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(8), .TO_WIDTH(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk_cmd(input string tag, input logic [1:0] t, input logic [3:0] a,
                           input logic [7:0] wd, input logic [7:0] oa,
                           input logic [7:0] ob, input logic [3:0] f);
        chk({tag, "_valid"}, 16'(bus.cmd_valid), 16'd1);
        chk({tag, "_type"},  16'(bus.cmd_type),  16'(t));
        chk({tag, "_addr"},  16'(bus.cmd_addr),  16'(a));
        chk({tag, "_wdata"}, 16'(bus.cmd_wdata), 16'(wd));
        chk({tag, "_op_a"},  16'(bus.cmd_op_a),  16'(oa));
        chk({tag, "_op_b"},  16'(bus.cmd_op_b),  16'(ob));
        chk({tag, "_func"},  16'(bus.cmd_func),  16'(f));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_all"}, {bus.cmd_valid, bus.cmd_type, bus.cmd_addr, bus.cmd_func,
                            bus.opcode_err, bus.timeout_err, bus.overrun_err, 3'd0}, 16'd0);
        chk({tag, "_data"}, {bus.cmd_wdata, bus.cmd_op_a}, 16'd0);
        chk({tag, "_opb"}, 16'(bus.cmd_op_b), 16'd0);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.cmd_ready = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b1;
        tick();

        // RF_WR with ready already high: one-cycle valid
        bus.cmd_ready = 1'b1;
        send(8'hAA);
        send(8'h35);
        chk("wr_not_yet", 16'(bus.cmd_valid), 16'd0);
        send(8'h5C);
        chk_cmd("rf_wr", 2'd0, 4'h5, 8'h5C, 8'h00, 8'h00, 4'h0);
        tick();
        chk("wr_drop", 16'(bus.cmd_valid), 16'd0);
        chk("wr_keep", 16'(bus.cmd_wdata), 16'h5C);

        // ALU_OPER held five cycles
        bus.cmd_ready = 1'b0;
        send(8'hCC);
        send(8'h12);
        send(8'h34);
        send(8'h07);
        chk_cmd("alu_op", 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h7);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alu_hold", {bus.cmd_valid, bus.cmd_op_a, 7'd0}, {1'b1, 8'h12, 7'd0});
        end
        bus.cmd_ready = 1'b1;
        tick();
        chk("alu_drop", 16'(bus.cmd_valid), 16'd0);

        // Overrun, then back-to-back opcode on the transfer edge
        bus.cmd_ready = 1'b0;
        send(8'hDD);
        send(8'h05);
        chk_cmd("nop5", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h5);
        send(8'hBB);
        chk("ovr_pulse", 16'(bus.overrun_err), 16'd1);
        chk_cmd("ovr_keep", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h5);
        tick();
        chk("ovr_end", 16'(bus.overrun_err), 16'd0);
        bus.cmd_ready = 1'b1;
        send(8'hBB);
        bus.cmd_ready = 1'b0;
        chk("b2b_valid", 16'(bus.cmd_valid), 16'd0);
        chk("b2b_type", 16'(bus.cmd_type), 16'd1);
        chk("b2b_noovr", 16'(bus.overrun_err), 16'd0);
        send(8'h0F);
        chk_cmd("rf_rd", 2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0);
        bus.cmd_ready = 1'b1;
        tick();
        chk("rd_drop", 16'(bus.cmd_valid), 16'd0);

        // Unknown opcode
        send(8'h42);
        chk("operr_pulse", {15'd0, bus.opcode_err}, 16'd1);
        chk("operr_novalid", 16'(bus.cmd_valid), 16'd0);
        chk("operr_fields", {bus.cmd_type, bus.cmd_addr}, 16'h001F);
        tick();
        chk("operr_end", 16'(bus.opcode_err), 16'd0);
        send(8'hDD);
        send(8'h0A);
        chk_cmd("nopA", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA);
        tick();

        // Timeout after 8 idle cycles
        send(8'hAA);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_early", 16'(bus.timeout_err), 16'd0);
        end
        tick();
        chk("to_pulse", 16'(bus.timeout_err), 16'd1);
        chk("to_novalid", 16'(bus.cmd_valid), 16'd0);
        tick();
        chk("to_end", 16'(bus.timeout_err), 16'd0);
        send(8'h55);
        chk("to_idle", 16'(bus.opcode_err), 16'd1);
        bus.cmd_ready = 1'b0;
        send(8'hAA);
        send(8'h01);
        send(8'h02);
        chk_cmd("after_to", 2'd0, 4'h1, 8'h02, 8'h00, 8'h00, 4'h0);
        bus.cmd_ready = 1'b1;
        tick();

        // Byte on the expiry cycle wins
        bus.cmd_ready = 1'b0;
        send(8'hAA);
        for (int i = 0; i < 7; i++) tick();
        send(8'h03);
        chk("edge_noto", 16'(bus.timeout_err), 16'd0);
        send(8'h04);
        chk_cmd("edge_wr", 2'd0, 4'h3, 8'h04, 8'h00, 8'h00, 4'h0);
        bus.cmd_ready = 1'b1;
        tick();

        // Reset while collecting operand B
        send(8'hCC);
        send(8'h11);
        chk("pre_rst_opa", 16'(bus.cmd_op_a), 16'h11);
        rst = 1'b0;
        tick();
        chk_zero("mid_rst");
        rst = 1'b1;
        bus.cmd_ready = 1'b0;
        send(8'hDD);
        send(8'h03);
        chk_cmd("post_rst", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
